// File: rtl/sram_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sram_arb_pkg
// Description : Shared widths and command encodings for the two-port SRAM
//               arbiter, plus a small helper for the round-robin pointer.
//               ADDR_W    SRAM word address width (256 words)
//               DATA_W    SRAM word width
//               CMD_READ  wen value for a read  (SRAM WEN convention)
//               CMD_WRITE wen value for a write
// Revision    : 1.0 - initial release
// ============================================================================
package sram_arb_pkg;

    localparam int   ADDR_W    = 8;
    localparam int   DATA_W    = 64;
    localparam logic CMD_READ  = 1'b1;
    localparam logic CMD_WRITE = 1'b0;

    // With two requesters the port that did not win is always the other one.
    function automatic logic other_port(input logic k);
        return ~k;
    endfunction

endpackage : sram_arb_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Purely combinational two-way round-robin decision.
//               i_req[1:0]  request vector (bit n = requester n)
//               i_ptr       priority pointer (k = requester k wins a tie)
//               o_gnt[1:0]  one-hot grant, all-zero when nobody requests
//               o_gnt_any   some requester is granted
//               o_gnt_idx   index of the granted requester
//               o_ptr_nxt   pointer value for the next edge
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] i_req,
    input  logic       i_ptr,
    output logic [1:0] o_gnt,
    output logic       o_gnt_any,
    output logic       o_gnt_idx,
    output logic       o_ptr_nxt
);
    import sram_arb_pkg::*;

    logic w_idx;

    // Tie goes to the pointer; a sole requester wins regardless. For the
    // patterns 01 and 10 the index is simply req[1].
    always_comb begin
        w_idx = (i_req == 2'b11) ? i_ptr : i_req[1];
    end

    assign o_gnt_any = |i_req;
    assign o_gnt_idx = w_idx;
    assign o_gnt     = o_gnt_any ? (w_idx ? 2'b10 : 2'b01) : 2'b00;
    // Loser of this grant gets priority next; no grant leaves the pointer.
    assign o_ptr_nxt = o_gnt_any ? other_port(w_idx) : i_ptr;

endmodule : rr_arb2
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sram_arbiter
// Description : Two-requester round-robin front end for a single-port SRAM.
//               One command per cycle is passed combinationally to the SRAM;
//               read data returns one cycle after the grant on the owning
//               port. The SRAM macro itself lives at the parent level.
// Ports       : CLK, reset             clock / async active-high reset
//               req_n, wen_n, addr_n,  requester n command (n = 0, 1)
//               wdata_n
//               gnt_n                  command accepted this cycle
//               rvalid_n, rdata_n      read return (rdata 0 when not valid)
//               sram_cen/wen/a/d       SRAM command, sram_q SRAM read data
//               rd_pending             a read return is being delivered
// Revision    : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int ADDR_W = sram_arb_pkg::ADDR_W,
    parameter int DATA_W = sram_arb_pkg::DATA_W
) (
    input  logic              CLK,
    input  logic              reset,

    input  logic              req_0,
    input  logic              wen_0,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [DATA_W-1:0] wdata_0,
    output logic              gnt_0,
    output logic              rvalid_0,
    output logic [DATA_W-1:0] rdata_0,

    input  logic              req_1,
    input  logic              wen_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    output logic              gnt_1,
    output logic              rvalid_1,
    output logic [DATA_W-1:0] rdata_1,

    output logic              sram_cen,
    output logic              sram_wen,
    output logic [ADDR_W-1:0] sram_a,
    output logic [DATA_W-1:0] sram_d,
    input  logic [DATA_W-1:0] sram_q,

    output logic              rd_pending
);
    import sram_arb_pkg::*;

    logic [1:0]        w_req;
    logic [1:0]        w_gnt;
    logic              w_gnt_any;
    logic              w_gnt_idx;
    logic              w_ptr_nxt;
    logic              w_sel_wen;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_rd_grant;

    logic              r_ptr;
    logic              r_rd_valid;
    logic              r_rd_owner;

    // Reset is asynchronous, so requests are masked combinationally as well:
    // no grant and no SRAM access may appear while reset is high.
    assign w_req = {req_1 & ~reset, req_0 & ~reset};

    rr_arb2 u_rr_arb2 (
        .i_req     (w_req),
        .i_ptr     (r_ptr),
        .o_gnt     (w_gnt),
        .o_gnt_any (w_gnt_any),
        .o_gnt_idx (w_gnt_idx),
        .o_ptr_nxt (w_ptr_nxt)
    );

    assign gnt_0 = w_gnt[0];
    assign gnt_1 = w_gnt[1];

    assign w_sel_wen   = w_gnt_idx ? wen_1   : wen_0;
    assign w_sel_addr  = w_gnt_idx ? addr_1  : addr_0;
    assign w_sel_wdata = w_gnt_idx ? wdata_1 : wdata_0;
    assign w_rd_grant  = w_gnt_any && (w_sel_wen == CMD_READ);

    // SRAM command: granted port passes straight through, otherwise idle.
    always_comb begin
        sram_cen = 1'b1;
        sram_wen = CMD_READ;
        sram_a   = '0;
        sram_d   = '0;
        if (w_gnt_any) begin
            sram_cen = 1'b0;
            sram_wen = w_sel_wen;
            sram_a   = w_sel_addr;
            sram_d   = w_sel_wdata;
        end
    end

    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_ptr <= 1'b0;
        end else begin
            r_ptr <= w_ptr_nxt;
        end
    end

    // Owner tracking for the single outstanding read. Reset drops a read in
    // flight; it is never replayed.
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            r_rd_valid <= 1'b0;
            r_rd_owner <= 1'b0;
        end else begin
            r_rd_valid <= w_rd_grant;
            if (w_rd_grant) begin
                r_rd_owner <= w_gnt_idx;
            end
        end
    end

    assign rvalid_0   = r_rd_valid & ~r_rd_owner;
    assign rvalid_1   = r_rd_valid &  r_rd_owner;
    assign rdata_0    = rvalid_0 ? sram_q : '0;
    assign rdata_1    = rvalid_1 ? sram_q : '0;
    assign rd_pending = r_rd_valid;

endmodule : sram_arbiter
`default_nettype wire

// File: doc/sram_arbiter.md
SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 Parameter: ADDR_W, 8, SRAM word address width (256 words).
REQ-002 Parameter: DATA_W, 64, SRAM word width.
REQ-003 Clock and reset SHALL be one clock and an asynchronous, active-high reset, with ports as follows:
  - CLK  in  1  single clock, rising-edge.
  - reset  in  1  asynchronous, active-high.
REQ-004 Requester ports (n = 0, 1) SHALL be:
  - req_n  in  1  request, held high until granted.
  - wen_n  in  1  1 = read, 0 = write (SRAM WEN convention).
  - addr_n  in  ADDR_W  word address.
  - wdata_n  in  DATA_W  write data.
  - gnt_n  out  1  command accepted this cycle.
  - rvalid_n  out  1  read data valid on rdata_n this cycle.
  - rdata_n  out  DATA_W  read data.
REQ-005 SRAM-side ports SHALL be:
  - sram_cen  out  1  chip enable, active-low.
  - sram_wen  out  1  1 = read, 0 = write.
  - sram_a  out  ADDR_W  address.
  - sram_d  out  DATA_W  write data.
  - sram_q  in  DATA_W  read data, valid the cycle after a read edge.
REQ-006 Status port: rd_pending  out  1  a granted read is awaiting its rvalid cycle.

Function
REQ-010 The block SHALL grant at most one requester per cycle; gnt_n SHALL be combinational from req_n and the priority pointer.
REQ-011 The priority pointer SHALL be 1 bit; value k gives requester k priority when both request.
REQ-012 After any grant to requester k, the pointer SHALL become 1-k at the next edge; with no grant the pointer SHALL hold.
REQ-013 A sole requester SHALL be granted in the same cycle regardless of the pointer.
REQ-014 In a grant cycle, the SRAM outputs SHALL be driven combinationally from the granted port:
  - sram_cen=0.
  - sram_wen=wen_k.
  - sram_a=addr_k.
  - sram_d=wdata_k.
REQ-015 With no grant, the SRAM outputs SHALL idle at sram_cen=1, sram_wen=1, sram_a=0, sram_d=0.
REQ-016 A granted read SHALL register owner k; in the following cycle rvalid_k=1 and rdata_k=sram_q (read latency exactly 1 cycle after gnt).
REQ-017 rvalid_n SHALL be a one-cycle pulse; rdata_n SHALL be driven 0 when rvalid_n=0.
REQ-018 Writes SHALL produce no rvalid; a write SHALL complete at the edge ending its gnt cycle.
REQ-019 Back-to-back grants SHALL be allowed every cycle (full throughput). A read granted in cycle t and a grant in cycle t+1 SHALL both proceed: rvalid in t+1 is for the cycle-t read.
REQ-020 Read-after-write to the same address in consecutive grants SHALL return the new data, since commands are serialized in grant order.
REQ-021 Each requester SHALL be granted within 2 cycles of raising req while both requesters are continuously active (starvation bound).
REQ-022 rd_pending SHALL be 1 exactly in the cycles where some rvalid_n=1.
REQ-023 A requester dropping req without a grant SHALL be legal and SHALL cause no SRAM access.

Reset
REQ-030 While reset=1:
  - pointer=0.
  - owner register cleared.
  - rd_pending=0.
  - rvalid_0=rvalid_1=0.
  - gnt_0=gnt_1=0.
  - SRAM outputs at idle values.
REQ-031 Reset asserted in the cycle after a read grant SHALL suppress that read's rvalid; the read SHALL NOT be replayed after reset.
REQ-032 The first grant after reset deassertion SHALL follow REQ-010..013 with pointer=0.

Structure
REQ-040 Package sram_arb_pkg SHALL hold ADDR_W, DATA_W, CMD_READ=1'b1 and CMD_WRITE=1'b0.
REQ-041 The two-way round-robin decision (req, pointer -> gnt, next pointer) SHALL be a sub-module rr_arb2.
REQ-042 The SRAM macro SHALL NOT be instantiated inside sram_arbiter; it connects at the parent level.

Verification (bench instantiates sram_arbiter plus the 64b x 256 SRAM model)
REQ-050 Stimulus: req_0 writes 64'hDEAD_BEEF_0000_0001 to addr 8'h05 (sole requester), then reads 8'h05. Response: gnt_0 in each request cycle; rvalid_0=1 one cycle after the read gnt with rdata_0=64'hDEAD_BEEF_0000_0001.
REQ-051 Stimulus: both req high for 6 cycles after reset, both reads. Response: grant sequence 0,1,0,1,0,1; each rvalid follows its gnt by 1 cycle with the matching address data.
REQ-052 Stimulus: req_1 writes 8'hFF, and req_0 reads 8'hFF in the next cycle. Response: rdata_0 equals the req_1 write data.
REQ-053 Stimulus: a read is granted to port 1 in cycle t, and reset pulses in cycle t+1. Response: rvalid_1=0 throughout; the pointer is 0 after reset.
REQ-054 Stimulus: idle cycles with no req. Response: sram_cen=1, sram_wen=1, sram_a=0, sram_d=0; the pointer is unchanged.
REQ-055 Stimulus: req_0 held continuously while req_1 pulses once. Response: gnt_1 within 2 cycles, and req_0 is never starved for more than 1 cycle.
